// File: rtl/alu_pkg.sv
// Shared definitions for nibble_alu: operation codes, {Z,N,H,C} flag bit positions,
// controller states and the nibble-slice function select.
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_ADC  = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_SBC  = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4;
   localparam logic [4:0] OP_XOR  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_CP   = 5'd7;
   localparam logic [4:0] OP_RLC  = 5'd8;
   localparam logic [4:0] OP_RRC  = 5'd9;
   localparam logic [4:0] OP_RL   = 5'd10;
   localparam logic [4:0] OP_RR   = 5'd11;
   localparam logic [4:0] OP_SLA  = 5'd12;
   localparam logic [4:0] OP_SRA  = 5'd13;
   localparam logic [4:0] OP_SWAP = 5'd14;
   localparam logic [4:0] OP_SRL  = 5'd15;
   localparam logic [4:0] OP_DAA  = 5'd16;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_H = 1;
   localparam int FLAG_C = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      NF_ADD = 3'd0,
      NF_SUB = 3'd1,
      NF_AND = 3'd2,
      NF_XOR = 3'd3,
      NF_OR  = 3'd4
   } nib_fn_e;

   // Codes 0..7 are the nibble-serial arithmetic/logic group.
   function automatic logic is_serial(input logic [4:0] op);
      return (op[4:3] == 2'b00);
   endfunction

   function automatic logic uses_carry_in(input logic [4:0] op);
      return (op == OP_ADC) || (op == OP_SBC);
   endfunction

   function automatic nib_fn_e nib_fn(input logic [4:0] op);
      nib_fn_e fn;
      case (op)
         OP_ADD, OP_ADC:        fn = NF_ADD;
         OP_SUB, OP_SBC, OP_CP: fn = NF_SUB;
         OP_AND:                fn = NF_AND;
         OP_XOR:                fn = NF_XOR;
         OP_OR:                 fn = NF_OR;
         default:               fn = NF_ADD;
      endcase
      return fn;
   endfunction

endpackage

// File: rtl/alu_nibble.sv
// 4-bit add/subtract/logic slice; for subtraction cin/cout carry borrow, not carry.
module alu_nibble
   import alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic [2:0] fn,
   output logic [3:0] y,
   output logic       cout
);

   logic [4:0] wide;

   // Slice function select; logic functions never produce a carry.
   always_comb begin
      wide = 5'b00000;
      y    = 4'h0;
      cout = 1'b0;
      case (fn)
         NF_ADD: begin
            wide = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
            y    = wide[3:0];
            cout = wide[4];
         end
         NF_SUB: begin
            wide = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
            y    = wide[3:0];
            cout = wide[4];
         end
         NF_AND:  y = a & b;
         NF_XOR:  y = a ^ b;
         NF_OR:   y = a | b;
         default: y = 4'h0;
      endcase
   end

endmodule

// File: rtl/nibble_alu.sv
// Multi-cycle ALU: arithmetic/logic one nibble per cycle (nibble 0 at the accept edge),
// shifts/rotates in one cycle. Optional DAA on op 5'b10000 when ALU_DAA_EN is defined.
module nibble_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   input  logic [3:0]       flags_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic [3:0]       flags_out
);

   localparam int         NIB      = WIDTH / 4;
   localparam int         HALF     = WIDTH / 2;
   localparam logic [1:0] LAST_IDX = 2'(NIB - 1);
   localparam logic [1:0] H_IDX    = 2'(NIB - 2);

   state_e           state_r, state_next_s;
   logic [4:0]       op_r;
   logic [WIDTH-1:0] lhs_r, rhs_r, acc_r, r_r;
   logic [3:0]       flags_r;
   logic             carry_r, h_r, out_valid_r;
   logic [1:0]       cnt_r;

   logic             in_ready_s, accept_s, step_s, last_s;
   logic [4:0]       cur_op_s;
   logic [WIDTH-1:0] cur_lhs_s, cur_rhs_s, acc_next_s, serial_r_s, sc_r_s;
   logic [1:0]       idx_s;
   logic [3:0]       sh_s, a_s, b_s, y_s, serial_f_s, sc_f_s;
   logic             cin_s, cout_s;
   nib_fn_e          cur_fn_s;

   function automatic logic [WIDTH+3:0] single_op(input logic [4:0]       o,
                                                 input logic [WIDTH-1:0] l,
                                                 input logic [3:0]       f);
      logic [WIDTH-1:0] res;
      logic             c;
      logic [3:0]       fo;
`ifdef ALU_DAA_EN
      logic [7:0]       v, corr, dres;
      logic             dc;
`endif
      res = l;
      c   = 1'b0;
      fo  = f;
      if (o[4] == 1'b0) begin
         case (o)
            OP_RLC:  begin res = {l[WIDTH-2:0], l[WIDTH-1]};   c = l[WIDTH-1]; end
            OP_RRC:  begin res = {l[0], l[WIDTH-1:1]};         c = l[0];       end
            OP_RL:   begin res = {l[WIDTH-2:0], f[FLAG_C]};    c = l[WIDTH-1]; end
            OP_RR:   begin res = {f[FLAG_C], l[WIDTH-1:1]};    c = l[0];       end
            OP_SLA:  begin res = {l[WIDTH-2:0], 1'b0};         c = l[WIDTH-1]; end
            OP_SRA:  begin res = {l[WIDTH-1], l[WIDTH-1:1]};   c = l[0];       end
            OP_SWAP: begin res = {l[HALF-1:0], l[WIDTH-1:HALF]}; c = 1'b0;     end
            OP_SRL:  begin res = {1'b0, l[WIDTH-1:1]};         c = l[0];       end
            default: begin res = l;                            c = 1'b0;       end
         endcase
         fo = {(res == {WIDTH{1'b0}}), 1'b0, 1'b0, c};
      end
`ifdef ALU_DAA_EN
      else if (o == OP_DAA) begin
         v    = l[7:0];
         corr = 8'h00;
         dc   = f[FLAG_C];
         if (f[FLAG_N] == 1'b0) begin
            if (f[FLAG_C] || (v > 8'h99)) begin
               corr = corr | 8'h60;
               dc   = 1'b1;
            end else begin
               corr = corr;
            end
            if (f[FLAG_H] || (v[3:0] > 4'h9)) corr = corr | 8'h06;
            else                              corr = corr;
            dres = v + corr;
         end else begin
            if (f[FLAG_C]) corr = corr | 8'h60;
            else           corr = corr;
            if (f[FLAG_H]) corr = corr | 8'h06;
            else           corr = corr;
            dres = v - corr;
         end
         res[7:0] = dres;
         fo       = {(dres == 8'h00), f[FLAG_N], 1'b0, dc};
      end
`endif
      else begin
         res = l;
         fo  = f;
      end
      return {res, fo};
   endfunction

   assign in_ready_s = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
   assign accept_s   = in_valid & in_ready_s;

   // Operand/nibble select: live inputs on the accept edge, registered copies while running.
   always_comb begin
      cur_op_s  = op_r;
      cur_lhs_s = lhs_r;
      cur_rhs_s = rhs_r;
      idx_s     = cnt_r;
      cin_s     = carry_r;
      if (accept_s) begin
         cur_op_s  = op;
         cur_lhs_s = lhs;
         cur_rhs_s = rhs;
         idx_s     = 2'd0;
         cin_s     = uses_carry_in(op) ? flags_in[FLAG_C] : 1'b0;
      end else begin
         cur_op_s  = op_r;
      end
      cur_fn_s = nib_fn(cur_op_s);
      sh_s     = {idx_s, 2'b00};
      a_s      = 4'(cur_lhs_s >> sh_s);
      b_s      = 4'(cur_rhs_s >> sh_s);
      step_s   = (accept_s & is_serial(op)) | (state_r == ST_RUN);
      last_s   = (idx_s == LAST_IDX);
   end

   alu_nibble u_slice (
      .a    (a_s),
      .b    (b_s),
      .cin  (cin_s),
      .fn   (cur_fn_s),
      .y    (y_s),
      .cout (cout_s)
   );

   // Result assembly and flag derivation for the serial group and the single-cycle group.
   always_comb begin
      acc_next_s = ((accept_s ? {WIDTH{1'b0}} : acc_r) & ~(WIDTH'(4'hF) << sh_s))
                 | (WIDTH'(y_s) << sh_s);
      serial_r_s = (cur_op_s == OP_CP) ? cur_lhs_s : acc_next_s;
      serial_f_s = 4'b0000;
      serial_f_s[FLAG_Z] = (acc_next_s == {WIDTH{1'b0}});
      serial_f_s[FLAG_N] = (cur_fn_s == NF_SUB);
      case (cur_fn_s)
         NF_ADD, NF_SUB: begin
            serial_f_s[FLAG_H] = h_r;
            serial_f_s[FLAG_C] = cout_s;
         end
         NF_AND: begin
            serial_f_s[FLAG_H] = 1'b1;
            serial_f_s[FLAG_C] = 1'b0;
         end
         default: begin
            serial_f_s[FLAG_H] = 1'b0;
            serial_f_s[FLAG_C] = 1'b0;
         end
      endcase
      {sc_r_s, sc_f_s} = single_op(op, lhs, flags_in);
   end

   // Controller next state.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_next_s = is_serial(op) ? ST_RUN : ST_DONE;
            else          state_next_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_s) state_next_s = ST_DONE;
            else        state_next_s = ST_RUN;
         end
         ST_DONE: begin
            if (accept_s)       state_next_s = is_serial(op) ? ST_RUN : ST_DONE;
            else if (out_ready) state_next_s = ST_IDLE;
            else                state_next_s = ST_DONE;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_next_s;
   end

   // Operand capture, per-nibble accumulation and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r        <= 5'd0;
         lhs_r       <= {WIDTH{1'b0}};
         rhs_r       <= {WIDTH{1'b0}};
         acc_r       <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         h_r         <= 1'b0;
         cnt_r       <= 2'd0;
         r_r         <= {WIDTH{1'b0}};
         flags_r     <= 4'b0000;
         out_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            op_r  <= op;
            lhs_r <= lhs;
            rhs_r <= rhs;
         end
         if (step_s) begin
            acc_r   <= acc_next_s;
            carry_r <= cout_s;
            cnt_r   <= last_s ? 2'd0 : idx_s + 2'd1;
            if (idx_s == H_IDX) h_r <= cout_s;
         end
         if (accept_s && !is_serial(op)) begin
            r_r     <= sc_r_s;
            flags_r <= sc_f_s;
         end else if ((state_r == ST_RUN) && last_s) begin
            r_r     <= serial_r_s;
            flags_r <= serial_f_s;
         end
         out_valid_r <= (state_next_s == ST_DONE);
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign r         = r_r;
   assign flags_out = flags_r;

endmodule

// File: tb/tb_nibble_alu.sv
// Directed bench for nibble_alu at WIDTH 8 and WIDTH 16: vector table plus handshake corner cases.
module tb_nibble_alu;
   import alu_pkg::*;

   typedef struct {
      int         w;
      logic [4:0] op;
      logic [15:0] lhs;
      logic [15:0] rhs;
      logic [3:0] fin;
      logic [15:0] er;
      logic [3:0] ef;
      int         lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, iv, sel16, out_ready;
   logic [4:0]  op;
   logic [15:0] lhs, rhs;
   logic [3:0]  fin;
   logic        iv8, iv16, ir8, ir16, ov8, ov16, ov, ir;
   logic [7:0]  r8;
   logic [15:0] r16, r;
   logic [3:0]  f8, f16, f;
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   assign iv8  = iv & ~sel16;
   assign iv16 = iv & sel16;
   assign ov   = sel16 ? ov16 : ov8;
   assign ir   = sel16 ? ir16 : ir8;
   assign r    = sel16 ? r16 : {8'h00, r8};
   assign f    = sel16 ? f16 : f8;

   nibble_alu #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op),
      .lhs(lhs[7:0]), .rhs(rhs[7:0]), .flags_in(fin), .out_valid(ov8),
      .out_ready(out_ready), .r(r8), .flags_out(f8)
   );

   nibble_alu #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op),
      .lhs(lhs), .rhs(rhs), .flags_in(fin), .out_valid(ov16),
      .out_ready(out_ready), .r(r16), .flags_out(f16)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int   lat;
      logic seen;
      @(negedge clk);
      sel16 = (v.w == 16);
      op = v.op; lhs = v.lhs; rhs = v.rhs; fin = v.fin; iv = 1'b1;
      @(posedge clk);
      #1;
      iv = 1'b0; op = OP_SUB; lhs = 16'hA5C3; rhs = 16'h5A3C; fin = 4'b0101;
      lat  = 0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         lat++;
         if (ov) seen = 1'b1;
      end
      check({tag, " r"}, r, v.er);
      check({tag, " flags"}, {12'h000, f}, {12'h000, v.ef});
      check({tag, " latency"}, 16'(lat), 16'(v.lat));
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0; iv = 1'b0; sel16 = 1'b0; out_ready = 1'b1;
      op = 5'd0; lhs = 16'h0000; rhs = 16'h0000; fin = 4'b0000;

      //            w   op        lhs        rhs        fin      er         ef      lat
      vecs.push_back('{8,  OP_ADD,  16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011, 2});
      vecs.push_back('{16, OP_ADD,  16'h0FFF, 16'h0001, 4'b0001, 16'h1000, 4'b0010, 4});
      vecs.push_back('{16, OP_ADC,  16'h0FFF, 16'h0001, 4'b0001, 16'h1001, 4'b0010, 4});
      vecs.push_back('{8,  OP_SBC,  16'h0010, 16'h000F, 4'b0001, 16'h0000, 4'b1110, 2});
      vecs.push_back('{8,  OP_CP,   16'h0010, 16'h0020, 4'b0000, 16'h0010, 4'b0101, 2});
      vecs.push_back('{8,  OP_RL,   16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001, 1});
      vecs.push_back('{8,  OP_SUB,  16'h0050, 16'h0021, 4'b1111, 16'h002F, 4'b0110, 2});
      vecs.push_back('{8,  OP_ADC,  16'h000E, 16'h0001, 4'b0001, 16'h0010, 4'b0010, 2});
      vecs.push_back('{8,  OP_AND,  16'h00F0, 16'h003C, 4'b0000, 16'h0030, 4'b0010, 2});
      vecs.push_back('{8,  OP_XOR,  16'h005A, 16'h005A, 4'b1111, 16'h0000, 4'b1000, 2});
      vecs.push_back('{8,  OP_OR,   16'h0012, 16'h0040, 4'b0000, 16'h0052, 4'b0000, 2});
      vecs.push_back('{8,  OP_RLC,  16'h0081, 16'h0000, 4'b0000, 16'h0003, 4'b0001, 1});
      vecs.push_back('{8,  OP_RRC,  16'h0001, 16'h0000, 4'b0000, 16'h0080, 4'b0001, 1});
      vecs.push_back('{8,  OP_RR,   16'h0002, 16'h0000, 4'b0001, 16'h0081, 4'b0000, 1});
      vecs.push_back('{8,  OP_SLA,  16'h00C1, 16'h0000, 4'b0000, 16'h0082, 4'b0001, 1});
      vecs.push_back('{8,  OP_SRA,  16'h0081, 16'h0000, 4'b0000, 16'h00C0, 4'b0001, 1});
      vecs.push_back('{8,  OP_SWAP, 16'h00A5, 16'h0000, 4'b1111, 16'h005A, 4'b0000, 1});
      vecs.push_back('{8,  OP_SRL,  16'h0001, 16'h0000, 4'b0000, 16'h0000, 4'b1001, 1});
      vecs.push_back('{16, OP_SWAP, 16'h1234, 16'h0000, 4'b0000, 16'h3412, 4'b0000, 1});
      vecs.push_back('{16, OP_SRA,  16'h8001, 16'h0000, 4'b0000, 16'hC000, 4'b0001, 1});
      vecs.push_back('{16, OP_SUB,  16'h1000, 16'h0001, 4'b0000, 16'h0FFF, 4'b0110, 4});
      vecs.push_back('{16, OP_ADD,  16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b1001, 4});
      vecs.push_back('{8,  5'd17,   16'h0077, 16'h0011, 4'b1010, 16'h0077, 4'b1010, 1});
`ifdef ALU_DAA_EN
      vecs.push_back('{8,  OP_DAA,  16'h009A, 16'h0000, 4'b0000, 16'h0000, 4'b1001, 1});
`else
      vecs.push_back('{8,  OP_DAA,  16'h009A, 16'h0000, 4'b0000, 16'h009A, 4'b0000, 1});
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset out_valid8", {15'd0, ov8}, 16'h0000);
      check("reset r8", {8'h00, r8}, 16'h0000);
      check("reset flags8", {12'h000, f8}, 16'h0000);
      check("reset in_ready8", {15'd0, ir8}, 16'h0001);
      check("reset out_valid16", {15'd0, ov16}, 16'h0000);
      check("reset r16", r16, 16'h0000);
      check("reset in_ready16", {15'd0, ir16}, 16'h0001);

      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // Stall in DONE with out_ready low; a competing request must be ignored.
      @(negedge clk);
      sel16 = 1'b0; out_ready = 1'b0;
      op = OP_RL; lhs = 16'h0080; rhs = 16'h0000; fin = 4'b0000; iv = 1'b1;
      @(posedge clk);
      #1;
      op = OP_ADD; lhs = 16'h0011; rhs = 16'h0022; fin = 4'b0000;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d out_valid", k), {15'd0, ov}, 16'h0001);
         check($sformatf("stall%0d r", k), r, 16'h0000);
         check($sformatf("stall%0d flags", k), {12'h000, f}, 16'h0009);
         check($sformatf("stall%0d in_ready", k), {15'd0, ir}, 16'h0000);
      end
      iv = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("stall release out_valid", {15'd0, ov}, 16'h0000);
      check("stall release in_ready", {15'd0, ir}, 16'h0001);

      // Back-to-back ADDs: second accepted in the first's DONE cycle.
      @(negedge clk);
      op = OP_ADD; lhs = 16'h0001; rhs = 16'h0002; fin = 4'b0000; iv = 1'b1;
      @(posedge clk);
      #1;
      lhs = 16'h0010; rhs = 16'h0020;
      @(negedge clk);
      check("b2b run in_ready", {15'd0, ir}, 16'h0000);
      check("b2b run out_valid", {15'd0, ov}, 16'h0000);
      @(negedge clk);
      check("b2b first out_valid", {15'd0, ov}, 16'h0001);
      check("b2b first r", r, 16'h0003);
      check("b2b first in_ready", {15'd0, ir}, 16'h0001);
      @(posedge clk);
      #1;
      iv = 1'b0; lhs = 16'h00FF; rhs = 16'h00FF;
      @(negedge clk);
      check("b2b second run out_valid", {15'd0, ov}, 16'h0000);
      @(negedge clk);
      check("b2b second out_valid", {15'd0, ov}, 16'h0001);
      check("b2b second r", r, 16'h0030);
      check("b2b second flags", {12'h000, f}, 16'h0000);

      // Reset pulse in the middle of a 16-bit RUN discards the operation.
      @(negedge clk);
      @(negedge clk);
      sel16 = 1'b1;
      op = OP_ADD; lhs = 16'h0FFF; rhs = 16'h0001; fin = 4'b0000; iv = 1'b1;
      @(posedge clk);
      #1;
      iv = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ov) seen = 1'b1;
      end
      check("rst mid-run out_valid seen", {15'd0, seen}, 16'h0000);
      check("rst mid-run in_ready", {15'd0, ir}, 16'h0001);
      check("rst mid-run r", r, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
